// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback, owns the PC, raises sticky traps.
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        is_illegal,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        wb_enable,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        taken_branch,
    input  logic [31:0] branch_target,
    output logic        reg_we,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_MISALGN = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
    localparam logic [7:0] CNT_LAST      = 8'(MEM_TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        trap_q;
    logic [1:0]  cause_q;
    logic [7:0]  cnt_q;
    logic        misaligned;
    logic        in_wb;

    // A taken branch to a non-word-aligned target aborts the writeback.
    assign misaligned = taken_branch && (branch_target[1:0] != 2'b00);
    assign in_wb      = (state_q == S_WRITEBACK);

    assign state      = state_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign imem_req   = (state_q == S_FETCH);
    assign dmem_req   = (state_q == S_MEMORY);
    assign dmem_we    = (state_q == S_MEMORY) && is_store;
    assign retire     = in_wb && !misaligned;
    assign reg_we     = in_wb && !misaligned && wb_enable;

    // Main sequencer: state, PC, latched instruction, wait counter and trap record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= S_DECODE;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (is_illegal) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_load || is_store) begin
                        state_q <= S_MEMORY;
                    end else begin
                        state_q <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        state_q <= S_WRITEBACK;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    if (misaligned) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_MISALGN;
                    end else begin
                        pc_q    <= taken_branch ? branch_target : pc_q + 32'd4;
                        state_q <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    trap_q <= 1'b1;
                end
                default: begin
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                    cause_q <= 2'd0;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer.
// Expected retirements are queued per instruction and checked on the retire pulse.
module tb_core_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        is_illegal;
    logic        is_load;
    logic        is_store;
    logic        wb_enable;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        taken_branch;
    logic [31:0] branch_target;
    logic        reg_we;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;

    core_sequencer #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .is_illegal    (is_illegal),
        .is_load       (is_load),
        .is_store      (is_store),
        .wb_enable     (wb_enable),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .taken_branch  (taken_branch),
        .branch_target (branch_target),
        .reg_we        (reg_we),
        .retire        (retire),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    typedef struct {
        logic [31:0] pc_wb;
        logic [31:0] pc_nx;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_m;
    logic        nx_pend = 1'b0;
    logic [31:0] nx_pc;
    int          lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Retire monitor: pops the scoreboard and checks the PC one cycle later.
    always @(negedge clk) begin
        if (nx_pend) begin
            chk("pc_next", pc, nx_pc);
            nx_pend = 1'b0;
        end
        if (rst_n && retire) begin
            if (sb.size() == 0) begin
                chk("retire_unexp", {31'b0, retire}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("retire_pc", pc, e.pc_wb);
                chk("retire_we", {31'b0, reg_we}, {31'b0, e.we});
                nx_pend = 1'b1;
                nx_pc   = e.pc_nx;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        rst_n   = 1'b1;
        pc_m    = RST_PC;
        nx_pend = 1'b0;
    endtask

    // Entered and left at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] word, input bit ld, input bit st,
                             input bit we, input bit tk, input logic [31:0] tgt,
                             input int dwait, output int n);
        bit          mem;
        bit          mis;
        logic [31:0] nx;
        mem = ld | st;
        mis = tk && (tgt[1:0] != 2'b00);
        is_illegal    = 1'b0;
        is_load       = ld;
        is_store      = st;
        wb_enable     = we;
        taken_branch  = tk;
        branch_target = tgt;
        imem_rdata    = word;
        imem_ready    = 1'b1;
        dmem_ready    = 1'b0;
        nx = tk ? tgt : pc_m + 32'd4;
        if (!mis) sb.push_back('{pc_m, nx, we});
        chk("f_state", {29'b0, state}, 32'd0);
        chk("f_imem_req", {31'b0, imem_req}, 32'd1);
        chk("f_pc", pc, pc_m);
        @(negedge clk);
        n = 1;
        chk("d_state", {29'b0, state}, 32'd1);
        chk("d_instr", instr, word);
        @(negedge clk);
        n++;
        chk("e_state", {29'b0, state}, 32'd2);
        chk("e_dmem_req", {31'b0, dmem_req}, 32'd0);
        if (mem) begin
            for (int i = 0; i <= dwait; i++) begin
                @(negedge clk);
                n++;
                chk("m_state", {29'b0, state}, 32'd3);
                chk("m_dmem_req", {31'b0, dmem_req}, 32'd1);
                chk("m_dmem_we", {31'b0, dmem_we}, {31'b0, st});
                if (i == dwait) dmem_ready = 1'b1;
            end
        end
        @(negedge clk);
        n++;
        dmem_ready = 1'b0;
        chk("w_state", {29'b0, state}, 32'd4);
        chk("w_retire", {31'b0, retire}, {31'b0, !mis});
        chk("w_reg_we", {31'b0, reg_we}, {31'b0, we && !mis});
        @(negedge clk);
        n++;
        chk("end_state", {29'b0, state}, mis ? 32'd5 : 32'd0);
        if (!mis) pc_m = nx;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        is_illegal = 1'b0; is_load = 1'b0; is_store = 1'b0;
        wb_enable = 1'b0; dmem_ready = 1'b0;
        taken_branch = 1'b0; branch_target = 32'd0;
        pc_m = RST_PC;
        repeat (2) @(negedge clk);
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        chk("rst_cause", {30'b0, trap_cause}, 32'd0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        rst_n = 1'b1;

        run_instr(32'h0020_81b3, 0, 0, 1, 0, 32'h0, 0, lat);
        chk("lat_alu", lat, 32'd4);
        run_instr(32'h0041_0233, 0, 0, 1, 0, 32'h0, 0, lat);
        run_instr(32'h0f80_006f, 0, 0, 0, 1, 32'h100, 0, lat);
        run_instr(32'h0000_0463, 0, 0, 0, 1, 32'h80, 0, lat);
        run_instr(32'h0800_006f, 0, 0, 0, 1, 32'h100, 0, lat);
        run_instr(32'h0000_0463, 0, 0, 0, 0, 32'h80, 0, lat);
        run_instr(32'h0001_2083, 1, 0, 1, 0, 32'h0, 3, lat);
        chk("lat_load", lat, 32'd8);
        run_instr(32'h0011_2023, 0, 1, 0, 0, 32'h0, 1, lat);
        chk("lat_store", lat, 32'd6);
        run_instr(32'h0000_006f, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, lat);
        run_instr(32'h0020_81b3, 0, 0, 1, 0, 32'h0, 0, lat);

        run_instr(32'h0000_006f, 0, 0, 1, 1, 32'h102, 0, lat);
        for (int i = 0; i < 22; i++) begin
            chk("trap_state", {29'b0, state}, 32'd5);
            chk("trap_cause2", {30'b0, trap_cause}, 32'd2);
            chk("trap_pc", pc, pc_m);
            chk("trap_imem_req", {31'b0, imem_req}, 32'd0);
            @(negedge clk);
        end
        chk("trap_flag", {31'b0, trap}, 32'd1);
        do_reset();

        is_illegal = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("ill_d_state", {29'b0, state}, 32'd1);
        @(negedge clk);
        chk("ill_state", {29'b0, state}, 32'd5);
        chk("ill_cause", {30'b0, trap_cause}, 32'd1);
        chk("ill_trap", {31'b0, trap}, 32'd1);
        chk("ill_pc", pc, RST_PC);
        is_illegal = 1'b0;
        do_reset();

        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_fetch", {29'b0, state}, 32'd0);
            @(negedge clk);
        end
        chk("to_state", {29'b0, state}, 32'd5);
        chk("to_cause", {30'b0, trap_cause}, 32'd3);
        do_reset();

        imem_ready = 1'b1; is_load = 1'b1; dmem_ready = 1'b0;
        k = 0;
        while (state != 3'd3 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("arst_reach_mem", {29'b0, state}, 32'd3);
        chk("arst_req_before", {31'b0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_after", {31'b0, dmem_req}, 32'd0);
        chk("arst_state", {29'b0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; is_load = 1'b0;
        @(negedge clk);

        chk("sb_left", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
